// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS = 4;
    localparam int WORDS_PER_LINE    = 4;

    typedef enum logic [1:0] {
        ICACHE_IDLE   = 2'd0,
        ICACHE_REFILL = 2'd1,
        ICACHE_DRAIN  = 2'd2
    } icache_state_e;

    // Word-aligned address of word w within the 16-byte line at base.
    function automatic logic [31:0] line_word_addr(input logic [27:0] base, input logic [1:0] w);
        return {base, w, 2'b00};
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, word-serial line
// refill from the memory controller, and a flush path that lets an
// outstanding memory word drain before returning to idle.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        hit,
    output logic [31:0] hit_inst,
    input  logic        rob_clear,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    icache_state_e    state_q;
    logic [1:0]       cnt_q;
    logic             mc_req_q;
    logic [31:0]      mc_addr_q;
    logic [27:0]      base_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_word;
    logic [TAG_W-1:0]      fill_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  word_wr;
    logic                  unused_pc_bits;

    assign req_tag  = fetch_pc[31:4+INDEX_BITS];
    assign req_idx  = fetch_pc[3+INDEX_BITS:4];
    assign req_word = fetch_pc[3:2];
    assign fill_tag = base_q[27:INDEX_BITS];
    assign fill_idx = base_q[INDEX_BITS-1:0];

    // Byte offset within the word has no meaning for instruction fetch.
    assign unused_pc_bits = ^fetch_pc[1:0];

    // Hit path is purely combinational; no hit-under-miss.
    assign hit      = fetch_valid && (state_q == ICACHE_IDLE) && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
    assign hit_inst = data_q[req_idx][req_word];

    assign mc_req  = mc_req_q;
    assign mc_addr = mc_addr_q;

    // A returned word is kept only when the refill is not being flushed.
    assign word_wr = rdy_in && (state_q == ICACHE_REFILL) && mc_done && !rob_clear;

    // Line storage: written one word per accepted transfer, tag on the last.
    always_ff @(posedge clk_in) begin
        if (word_wr) begin
            data_q[fill_idx][cnt_q] <= mc_data;
            if (cnt_q == 2'd3) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

    // Refill controller with registered memory-request outputs and valid bits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ICACHE_IDLE;
            cnt_q     <= 2'd0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= 32'd0;
            base_q    <= 28'd0;
            valid_q   <= '0;
        end else if (rdy_in) begin
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (fetch_valid && !hit && !rob_clear) begin
                        base_q           <= fetch_pc[31:4];
                        valid_q[req_idx] <= 1'b0;
                        cnt_q            <= 2'd0;
                        mc_req_q         <= 1'b1;
                        mc_addr_q        <= line_word_addr(fetch_pc[31:4], 2'd0);
                        state_q          <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    if (mc_done && rob_clear) begin
                        mc_req_q <= 1'b0;
                        state_q  <= ICACHE_IDLE;
                    end else if (mc_done) begin
                        if (cnt_q == 2'd3) begin
                            valid_q[fill_idx] <= 1'b1;
                            mc_req_q          <= 1'b0;
                            state_q           <= ICACHE_IDLE;
                        end else begin
                            cnt_q     <= cnt_q + 2'd1;
                            mc_addr_q <= line_word_addr(base_q, cnt_q + 2'd1);
                        end
                    end else if (rob_clear) begin
                        // Word still outstanding: keep request stable until it lands.
                        state_q <= ICACHE_DRAIN;
                    end
                end
                ICACHE_DRAIN: begin
                    if (mc_done) begin
                        mc_req_q <= 1'b0;
                        state_q  <= ICACHE_IDLE;
                    end
                end
                default: begin
                    mc_req_q <= 1'b0;
                    state_q  <= ICACHE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random
// fetches, all checked against a line-level cache model and a memory image.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        hit;
    logic [31:0] hit_inst;
    logic        rob_clear;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Memory image covering 0x000-0xFFF, and a line-level model of the cache.
    logic [31:0] mem     [1024];
    logic        m_valid [16];
    logic [23:0] m_tag   [16];

    icache dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .hit         (hit),
        .hit_inst    (hit_inst),
        .rob_clear   (rob_clear),
        .mc_req      (mc_req),
        .mc_addr     (mc_addr),
        .mc_done     (mc_done),
        .mc_data     (mc_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic model_hit(input logic [31:0] pc);
        return m_valid[pc[7:4]] && (m_tag[pc[7:4]] == pc[31:8]);
    endfunction

    // Present a missing fetch and step into the refill.
    task automatic start_miss(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        cycle();
        m_valid[pc[7:4]] = 1'b0;
    endtask

    // Return word k of the line at base after lat idle cycles.
    task automatic serve_word(input logic [31:0] base, input int k, input int lat);
        for (int w = 0; w < lat; w++) begin
            chk("wait_req", {31'd0, mc_req}, 32'd1);
            chk("wait_addr", mc_addr, base + 32'(4 * k));
            cycle();
        end
        chk("refill_req", {31'd0, mc_req}, 32'd1);
        chk("refill_addr", mc_addr, base + 32'(4 * k));
        chk("refill_nohit", {31'd0, hit}, 32'd0);
        mc_done = 1'b1;
        mc_data = mem[(base >> 2) + 32'(k)];
        cycle();
        mc_done = 1'b0;
    endtask

    // Complete fetch transaction: hit check, or full refill and then hit.
    task automatic do_fetch(input logic [31:0] pc, input int lat);
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        if (model_hit(pc)) begin
            fetch_valid = 1'b1;
            fetch_pc    = pc;
            #1;
            chk("hit", {31'd0, hit}, 32'd1);
            chk("hit_inst", hit_inst, mem[pc[11:2]]);
            chk("hit_noreq", {31'd0, mc_req}, 32'd0);
            cycle();
            chk("hit_noreq_next", {31'd0, mc_req}, 32'd0);
        end else begin
            start_miss(pc);
            for (int k = 0; k < 4; k++) serve_word(base, k, lat);
            m_valid[pc[7:4]] = 1'b1;
            m_tag[pc[7:4]]   = pc[31:8];
            chk("fill_hit", {31'd0, hit}, 32'd1);
            chk("fill_inst", hit_inst, mem[pc[11:2]]);
            chk("fill_req_low", {31'd0, mc_req}, 32'd0);
        end
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc    = 32'd0;
        rob_clear   = 1'b0;
        mc_done     = 1'b0;
        mc_data     = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 24'd0;
        end

        // Reset state
        cycle();
        cycle();
        rst_in = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h4;
        #1;
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_req", {31'd0, mc_req}, 32'd0);
        chk("rst_addr", mc_addr, 32'd0);
        fetch_valid = 1'b0;
        cycle();

        // Cold miss, warm hit, and rob_clear in idle
        do_fetch(32'h4, 0);
        chk("cold_inst", hit_inst, 32'hA1);
        do_fetch(32'hC, 0);
        rob_clear = 1'b1;
        cycle();
        rob_clear = 1'b0;
        chk("idle_clear_req", {31'd0, mc_req}, 32'd0);
        do_fetch(32'h0, 0);

        // Conflict on index 0
        do_fetch(32'h104, 1);
        do_fetch(32'h4, 0);

        // Flush with third word outstanding; other line must not hit meanwhile
        do_fetch(32'h14, 0);
        start_miss(32'h204);
        serve_word(32'h200, 0, 0);
        serve_word(32'h200, 1, 0);
        chk("flush_addr", mc_addr, 32'h208);
        rob_clear = 1'b1;
        fetch_pc  = 32'h14;
        #1;
        chk("flush_nohit", {31'd0, hit}, 32'd0);
        cycle();
        chk("drain_req", {31'd0, mc_req}, 32'd1);
        chk("drain_addr", mc_addr, 32'h208);
        chk("drain_nohit", {31'd0, hit}, 32'd0);
        cycle();
        rob_clear = 1'b0;
        chk("drain_req2", {31'd0, mc_req}, 32'd1);
        chk("drain_addr2", mc_addr, 32'h208);
        mc_done = 1'b1;
        mc_data = 32'h5A5A_5A5A;
        cycle();
        mc_done = 1'b0;
        chk("drain_done_req", {31'd0, mc_req}, 32'd0);
        chk("after_drain_hit", {31'd0, hit}, 32'd1);
        chk("after_drain_inst", hit_inst, mem[5]);
        fetch_valid = 1'b0;
        do_fetch(32'h204, 1);

        // rob_clear together with the 4th word
        start_miss(32'h304);
        for (int k = 0; k < 3; k++) serve_word(32'h300, k, 0);
        chk("last_addr", mc_addr, 32'h30C);
        mc_done   = 1'b1;
        rob_clear = 1'b1;
        mc_data   = mem[32'hC3];
        cycle();
        mc_done   = 1'b0;
        rob_clear = 1'b0;
        chk("clr4_req", {31'd0, mc_req}, 32'd0);
        chk("clr4_nohit", {31'd0, hit}, 32'd0);
        fetch_valid = 1'b0;
        do_fetch(32'h30C, 0);

        // rdy_in low for 3 cycles mid-refill with spurious mc_done pulses
        start_miss(32'h404);
        serve_word(32'h400, 0, 0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mc_done = 1'b1;
            mc_data = 32'hDEAD_BEEF;
            cycle();
            chk("stall_addr", mc_addr, 32'h404);
            chk("stall_req", {31'd0, mc_req}, 32'd1);
        end
        mc_done = 1'b0;
        rdy_in  = 1'b1;
        for (int k = 1; k < 4; k++) serve_word(32'h400, k, 0);
        m_valid[0] = 1'b1;
        m_tag[0]   = 24'h4;
        chk("stall_hit", {31'd0, hit}, 32'd1);
        chk("stall_inst", hit_inst, mem[32'h101]);
        fetch_valid = 1'b0;

        // Asynchronous reset between clock edges during a refill
        start_miss(32'h504);
        serve_word(32'h500, 0, 0);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_req", {31'd0, mc_req}, 32'd0);
        chk("arst_addr", mc_addr, 32'd0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        fetch_valid = 1'b0;
        cycle();
        rst_in = 1'b0;
        cycle();
        do_fetch(32'h4, 0);

        // Random fetches over 64 lines mapping onto 16 indices
        for (int n = 0; n < 60; n++) begin
            do_fetch(32'($urandom_range(0, 255)) << 2, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. It answers fetch requests combinationally on a hit. On a miss it refills a 4-word line from the memory controller, one word at a time. A ROB flush aborts a refill safely, without losing memory-controller handshake state.

## Interface
Parameters:
- INDEX_BITS, 4, line-index width; number of lines = 2^INDEX_BITS (default 16 lines × 16 B = 256 B).

Ports:
- clk_in  in  1  clock; all state updates on its rising edge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- fetch_valid  in  1  fetch request from instruction fetch
- fetch_pc  in  32  request address, word-aligned
- hit  out  1  requested word available this cycle
- hit_inst  out  32  instruction word; meaningful only when hit=1
- rob_clear  in  1  pipeline flush from the ROB
- mc_req  out  1  word-read request to the memory controller
- mc_addr  out  32  word-aligned read address
- mc_done  in  1  one-cycle pulse: mc_data holds the requested word
- mc_data  in  32  returned word

## Operation
- Address split: tag = pc[31:4+INDEX_BITS], index = pc[3+INDEX_BITS:4], word = pc[3:2]; pc[1:0] ignored.
- Storage per line: valid bit, tag, and 4×32-bit words, all held in registers.
- hit = fetch_valid && state==IDLE && valid[index] && tag match.
- hit_inst = data[index][word]. It is driven whenever a line is selected; it is undefined-but-stable when hit=0.
- States: IDLE, REFILL, DRAIN.
- IDLE → REFILL: taken when rdy_in && fetch_valid && !hit && !rob_clear. On entry:
  - latch the line base (pc[31:4]);
  - clear valid[index];
  - cnt←0, mc_req←1, mc_addr←{base,2'b00,2'b00}.
- REFILL, on a cycle with mc_done (and rdy_in):
  - data[idx][cnt]←mc_data.
  - If cnt<3: cnt←cnt+1, mc_addr←{base,cnt+1,2'b00}, mc_req stays 1.
  - If cnt==3: write tag, set valid, mc_req←0, go to IDLE.
- REFILL, on rob_clear without mc_done: go to DRAIN; mc_req and mc_addr hold.
- DRAIN: on mc_done, discard the word, mc_req←0, go to IDLE. The line stays invalid. Further rob_clear in DRAIN has no effect.
- rob_clear together with mc_done in REFILL: the word is discarded (even if cnt==3), mc_req←0, go to IDLE, line stays invalid.
- rob_clear in IDLE: no state change.
- rdy_in low: all registers hold, and mc_done is ignored. The memory controller is gated by the same rdy_in.

## Timing
- Reset values:
  - state=IDLE, cnt=0, mc_req=0, mc_addr=0;
  - all valid bits=0, so hit=0;
  - tags and data are not reset.
- Hit latency: 0 cycles; hit rises in the same cycle fetch_valid is high.
- Miss:
  - mc_req rises the cycle after the miss.
  - hit rises in the cycle after the 4th mc_done, provided fetch_valid is still high.
  - With a 1-cycle memory controller, the miss penalty is 4 transfers plus entry and exit cycles.
- Memory handshake:
  - mc_req and mc_addr are stable from assertion until mc_done.
  - The memory controller treats the cycle after mc_done as a new request whenever mc_req is still high.
  - mc_req is never dropped while a word is outstanding.
- hit is 0 in REFILL and DRAIN even if another line would match (no hit-under-miss).
- A fetch arriving while in DRAIN waits; it is looked up once the cache returns to IDLE.

## Structure
- Add to const.v:
  - state encodings `ICACHE_IDLE`, `ICACHE_REFILL`, `ICACHE_DRAIN`;
  - `ICACHE_INDEX_BITS` as the default for INDEX_BITS.
- Single module; tag, valid and data arrays stay inline. No sub-module is warranted.
- Estimated 150–200 lines of RTL.

## Test plan
- Cold miss:
  - Stimulus: fetch_valid=1, fetch_pc=0x0000_0004; memory returns 0xA0,0xA1,0xA2,0xA3 with 1-cycle mc_done.
  - Expected: mc_addr sequence 0x0,0x4,0x8,0xC; then hit=1 with hit_inst=0xA1.
- Warm hit: after the above, fetch_pc=0x0000_000C → hit=1 in the same cycle, hit_inst=0xA3, mc_req stays 0.
- Conflict: fetch_pc=0x0000_0104 (INDEX_BITS=4, same index, different tag) → miss and refill from 0x100. A later fetch of 0x4 misses again.
- Flush mid-refill: rob_clear after the 2nd mc_done while the 3rd word is outstanding → mc_addr holds 0x8 until mc_done, then mc_req=0. Re-fetching 0x4 misses again.
- Simultaneous events:
  - rob_clear coinciding with the 4th mc_done → line invalid, state IDLE, mc_req=0 next cycle.
  - rdy_in=0 for 3 cycles mid-refill → cnt and mc_addr unchanged, and mc_done pulses during that window are ignored.
- Async reset: assert rst_in mid-refill, between clock edges → mc_req=0 immediately; a fetch of 0x4 then misses.
